// File: rtl/arilogcal_seq.sv
// Multi-cycle calculator: latches operands on an equal-key press, runs shift-add multiply /
// restoring divide, converts to BCD by double-dabble and drives active-low 7-segment digits.
module arilogcal_seq #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    ac,
  input  logic [WIDTH-1:0]        optA,
  input  logic [WIDTH-1:0]        optB,
  input  logic [2:0]              doOpt,
  input  logic                    equalTo,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*8-1:0] segs
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned BCD_D = (RES_W * 301) / 1000 + 1;
  localparam int unsigned BCD_W = 4 * BCD_D;
  localparam int unsigned MAX_D = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
  localparam int unsigned SIG_W = $clog2(MAX_D + 2);
  localparam int unsigned CNT_W = $clog2(RES_W + 1);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;

  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_MINUS = 8'hBF;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_R     = 8'hAF;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_CONV, S_SHOW} state_t;

  state_t               state, state_nxt;
  logic                 eq_q;
  logic [WIDTH-1:0]     a, b;
  logic [2:0]           op;
  logic [CNT_W-1:0]     cnt;
  logic [RES_W-1:0]     acc;
  logic [WIDTH-1:0]     dq;
  logic [WIDTH-1:0]     rem;
  logic                 neg, err;
  logic [RES_W-1:0]     bin;
  logic [BCD_W-1:0]     bcd;

  logic                 start_c, multi_c, exec_last_c, conv_last_c;
  logic                 busy_nxt, done_nxt;
  logic [RES_W-1:0]     acc_nxt, res_c;
  logic [WIDTH:0]       r_sh;
  logic                 r_ge;
  logic [WIDTH-1:0]     rem_nxt, q_nxt;
  logic                 err_op_c, neg_c;
  logic [BCD_W-1:0]     bcd_adj, bcd_nxt;
  logic [RES_W-1:0]     bin_nxt;
  logic [4*NUM_DIGITS-1:0] digs;
  logic [SIG_W-1:0]     sig_c;
  logic                 err_all_c;
  logic [NUM_DIGITS*8-1:0] seg_c;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = G_BLANK;
    endcase
  endfunction

  assign start_c     = eq_q & ~equalTo;
  assign multi_c     = (op == OP_MUL) || (op == OP_DIV);
  assign exec_last_c = !multi_c || (cnt == CNT_W'(WIDTH - 1));
  assign conv_last_c = (cnt == CNT_W'(RES_W - 1));

  // One shift-add multiply step and one restoring-divide step per EXEC cycle
  always_comb begin
    acc_nxt = (acc << 1) + (dq[WIDTH-1] ? RES_W'(a) : '0);
    r_sh    = {rem, dq[WIDTH-1]};
    r_ge    = (r_sh >= {1'b0, b});
    rem_nxt = r_ge ? (r_sh[WIDTH-1:0] - b) : r_sh[WIDTH-1:0];
    q_nxt   = {dq[WIDTH-2:0], r_ge};
  end

  always_comb begin
    res_c    = '0;
    neg_c    = 1'b0;
    err_op_c = 1'b0;
    case (op)
      OP_ADD: res_c = RES_W'(a) + RES_W'(b);
      OP_SUB: begin
        neg_c = (a < b);
        res_c = neg_c ? RES_W'(b - a) : RES_W'(a - b);
      end
      OP_MUL: res_c = acc_nxt;
      OP_DIV: begin
        res_c    = RES_W'(q_nxt);
        err_op_c = (b == '0);
      end
      OP_AND: res_c = RES_W'((a != '0) && (b != '0));
      OP_OR:  res_c = RES_W'((a != '0) || (b != '0));
      default: err_op_c = 1'b1;
    endcase
  end

  // Double-dabble step: add 3 to nibbles >= 5, then shift the whole {bcd, bin} left
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(BCD_D); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
  end

  // Display image built from the final BCD value on the last CONV cycle
  always_comb begin
    digs  = (4*NUM_DIGITS)'(bcd_nxt);
    sig_c = '0;
    for (int k = 0; k < int'(BCD_D); k++) begin
      if (bcd_nxt[4*k +: 4] != 4'd0) sig_c = SIG_W'(k + 1);
    end
    if (sig_c == '0) sig_c = SIG_W'(1);
    err_all_c = err || (({1'b0, sig_c} + (SIG_W+1)'(neg)) > (SIG_W+1)'(NUM_DIGITS));
    seg_c = '1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (err_all_c) begin
        if (k == 2)     seg_c[8*k +: 8] = G_E;
        else if (k < 2) seg_c[8*k +: 8] = G_R;
      end else if (SIG_W'(k) < sig_c) begin
        seg_c[8*k +: 8] = glyph(digs[4*k +: 4]);
      end else if (neg && (SIG_W'(k) == sig_c)) begin
        seg_c[8*k +: 8] = G_MINUS;
      end
    end
  end

  always_ff @(posedge clk or posedge ac) begin
    if (ac) state <= S_IDLE;
    else    state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: if (start_c) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_EXEC;
      S_EXEC: if (exec_last_c) state_nxt = S_CONV;
      S_CONV: if (conv_last_c) state_nxt = S_SHOW;
      S_SHOW: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_LOAD) || (state_nxt == S_EXEC) || (state_nxt == S_CONV);
    done_nxt = (state_nxt == S_SHOW);
  end

  // Key history resets to "pressed" so a key held through reset never starts an operation
  always_ff @(posedge clk or posedge ac) begin
    if (ac) begin
      eq_q <= 1'b0;
      a    <= '0;
      b    <= '0;
      op   <= '0;
      cnt  <= '0;
      acc  <= '0;
      dq   <= '0;
      rem  <= '0;
      neg  <= 1'b0;
      err  <= 1'b0;
      bin  <= '0;
      bcd  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      segs <= '1;
    end else begin
      eq_q <= equalTo;
      busy <= busy_nxt;
      done <= done_nxt;
      case (state)
        S_LOAD: begin
          a   <= optA;
          b   <= optB;
          op  <= doOpt;
          dq  <= (doOpt == OP_DIV) ? optA : optB;
          acc <= '0;
          rem <= '0;
          cnt <= '0;
        end
        S_EXEC: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          dq  <= (op == OP_DIV) ? q_nxt : (dq << 1);
          cnt <= cnt + CNT_W'(1);
          if (exec_last_c) begin
            bin <= res_c;
            bcd <= '0;
            neg <= neg_c;
            err <= err_op_c;
            cnt <= '0;
          end
        end
        S_CONV: begin
          bcd <= bcd_nxt;
          bin <= bin_nxt;
          cnt <= cnt + CNT_W'(1);
          if (conv_last_c) segs <= seg_c;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_arilogcal_seq.sv
// Scoreboard bench for arilogcal_seq (WIDTH=8, NUM_DIGITS=6): expected display and latency
// are queued at each press and compared when the operation completes.
module tb_arilogcal_seq;

  localparam int W = 8;
  localparam int N = 6;

  logic           clk = 1'b0;
  logic           ac;
  logic [W-1:0]   optA, optB;
  logic [2:0]     doOpt;
  logic           equalTo;
  logic           busy, done;
  logic [N*8-1:0] segs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N*8-1:0] segs;
    int             lat;
  } exp_t;
  exp_t sb[$];

  arilogcal_seq #(.WIDTH(W), .NUM_DIGITS(N)) dut (
    .clk(clk), .ac(ac), .optA(optA), .optB(optB), .doOpt(doOpt),
    .equalTo(equalTo), .busy(busy), .done(done), .segs(segs)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
      5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [N*8-1:0] model_segs(input int a, input int b, input int op);
    int v, t, sig;
    bit neg, err;
    int d[N+4];
    logic [N*8-1:0] r;
    v = 0; neg = 0; err = 0;
    case (op)
      1: v = a + b;
      2: begin neg = (a < b); v = neg ? b - a : a - b; end
      3: v = a * b;
      4: if (b == 0) err = 1; else v = a / b;
      5: v = (a != 0 && b != 0) ? 1 : 0;
      6: v = (a != 0 || b != 0) ? 1 : 0;
      default: err = 1;
    endcase
    t = v; sig = 0;
    for (int k = 0; k < N + 4; k++) begin
      d[k] = t % 10;
      t = t / 10;
      if (d[k] != 0) sig = k + 1;
    end
    if (sig == 0) sig = 1;
    if (sig + int'(neg) > N) err = 1;
    r = '1;
    if (err) begin
      r[23:16] = 8'h86; r[15:8] = 8'hAF; r[7:0] = 8'hAF;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (k < sig) r[8*k +: 8] = glyph(d[k]);
        else if (neg && k == sig) r[8*k +: 8] = 8'hBF;
      end
    end
    return r;
  endfunction

  task automatic push_exp(input int a, input int b, input int op);
    exp_t e;
    e.segs = model_segs(a, b, op);
    e.lat  = (op == 3 || op == 4) ? 2 + W + 2*W : 3 + 2*W;
    sb.push_back(e);
  endtask

  // Press the key at cycle 0 and observe a fixed window; optional re-press, optA change, reset
  task automatic press(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input int hold, input bit repress, input int chg_cycle,
                       input logic [W-1:0] chg_a, input int rst_cycle,
                       output int lat, output int dcnt, output logic [63:0] bh,
                       output logic [N*8-1:0] sdone, output logic [N*8-1:0] rsegs,
                       output logic rbusy);
    int win;
    win = (hold + 5 > 45) ? hold + 5 : 45;
    lat = -1; dcnt = 0; bh = '0; sdone = '0; rsegs = '0; rbusy = 1'b0;
    @(posedge clk); #1;
    optA = a; optB = b; doOpt = op; equalTo = 1'b0;
    bh[0] = busy;
    for (int i = 1; i <= win; i++) begin
      @(posedge clk); #1;
      if (i < 64) bh[i] = busy;
      if (done) begin
        dcnt++;
        if (lat < 0) begin lat = i; sdone = segs; end
      end
      if (repress && i == 3) equalTo = 1'b1;
      if (repress && i == 5) equalTo = 1'b0;
      if (i == hold) equalTo = 1'b1;
      if (i == chg_cycle) optA = chg_a;
      if (i == rst_cycle) begin
        ac = 1'b1; #1;
        rsegs = segs; rbusy = busy;
      end
      if (i == rst_cycle + 1) ac = 1'b0;
    end
    equalTo = 1'b1;
  endtask

  task automatic test_reset();
    ac = 1'b1; equalTo = 1'b1; optA = '0; optB = '0; doOpt = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (segs !== {N{8'hFF}}) begin errors++; $display("FAIL reset_segs got=%h exp=%h", segs, {N{8'hFF}}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    ac = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_simple(input string name, input int a, input int b, input int op);
    exp_t e; int lat, dc; logic [63:0] bh; logic [N*8-1:0] sd, rs; logic rb;
    push_exp(a, b, op);
    press(W'(a), W'(b), 3'(op), 2, 1'b0, -1, '0, -1, lat, dc, bh, sd, rs, rb);
    e = sb.pop_front();
    checks++; if (sd !== e.segs) begin errors++; $display("FAIL %s_segs got=%h exp=%h", name, sd, e.segs); end
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, e.lat); end
  endtask

  task automatic test_add();
    exp_t e; int lat, dc; logic [63:0] bh; logic [N*8-1:0] sd, rs; logic rb;
    push_exp(200, 100, 1);
    press(8'd200, 8'd100, 3'd1, 2, 1'b0, -1, '0, -1, lat, dc, bh, sd, rs, rb);
    e = sb.pop_front();
    checks++; if (sd !== e.segs) begin errors++; $display("FAIL add_segs got=%h exp=%h", sd, e.segs); end
    checks++; if (lat !== 19) begin errors++; $display("FAIL add_latency got=%0d exp=19", lat); end
    checks++; if (bh[19:0] !== 20'h7FFFE) begin errors++; $display("FAIL add_busy_window got=%h exp=7fffe", bh[19:0]); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL add_done_count got=%0d exp=1", dc); end
  endtask

  task automatic test_sub();
    run_simple("sub_neg", 5, 9, 2);
    run_simple("sub_zero", 9, 9, 2);
  endtask

  task automatic test_mul();
    exp_t e; int lat, dc; logic [63:0] bh; logic [N*8-1:0] sd, rs; logic rb;
    push_exp(255, 255, 3);
    press(8'd255, 8'd255, 3'd3, 40, 1'b0, -1, '0, -1, lat, dc, bh, sd, rs, rb);
    e = sb.pop_front();
    checks++; if (sd !== e.segs) begin errors++; $display("FAIL mul_segs got=%h exp=%h", sd, e.segs); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL mul_latency got=%0d exp=26", lat); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL mul_held_done_count got=%0d exp=1", dc); end
    run_simple("mul_zero", 0, 77, 3);
  endtask

  task automatic test_div();
    run_simple("div", 7, 2, 4);
    run_simple("div_by_zero", 7, 0, 4);
    run_simple("invalid_op0", 12, 3, 0);
    run_simple("invalid_op7", 12, 3, 7);
  endtask

  task automatic test_logic();
    exp_t e; int lat, dc; logic [63:0] bh; logic [N*8-1:0] sd, rs; logic rb;
    run_simple("and", 0, 3, 5);
    run_simple("or", 0, 3, 6);
    // re-press while busy and change optA mid-operation
    push_exp(0, 3, 5);
    press(8'd0, 8'd3, 3'd5, 8, 1'b1, 3, 8'd5, -1, lat, dc, bh, sd, rs, rb);
    e = sb.pop_front();
    checks++; if (sd !== e.segs) begin errors++; $display("FAIL and_optA_change got=%h exp=%h", sd, e.segs); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL busy_repress_done_count got=%0d exp=1", dc); end
  endtask

  task automatic test_reset_mid();
    int lat, dc; logic [63:0] bh; logic [N*8-1:0] sd, rs; logic rb;
    press(8'd255, 8'd255, 3'd3, 40, 1'b0, -1, '0, 5, lat, dc, bh, sd, rs, rb);
    checks++; if (rs !== {N{8'hFF}}) begin errors++; $display("FAIL midreset_segs got=%h exp=%h", rs, {N{8'hFF}}); end
    checks++; if (rb !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", rb); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL midreset_done_count got=%0d exp=0", dc); end
    run_simple("after_reset", 123, 45, 1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_logic();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
